// File: rtl/board_scanner.sv
// Board scanner: reads every board row once and reduces the rows to
// per-column heights, the min/max column, the full-row count and the hole count.
module board_scanner #(
    parameter int ROWS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        row_req,
    output logic [5:0]  row,
    input  logic [9:0]  row_info,
    output logic [49:0] heights,
    output logic [3:0]  min_col,
    output logic [4:0]  max_height,
    output logic [5:0]  full_rows,
    output logic [7:0]  holes
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    localparam logic [6:0] ROWS_W   = 7'(ROWS);

    state_e      state_q, state_d;
    logic [5:0]  row_q, row_d;
    logic [49:0] heights_q, heights_d;
    logic [3:0]  min_col_q, min_col_d;
    logic [4:0]  max_h_q, max_h_d;
    logic [5:0]  full_q, full_d;
    logic [7:0]  holes_q, holes_d;

    logic        clr;
    logic        samp;
    logic        calc;
    logic [5:0]  srow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            heights_q <= '0;
            min_col_q <= '0;
            max_h_q   <= '0;
            full_q    <= '0;
            holes_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            heights_q <= heights_d;
            min_col_q <= min_col_d;
            max_h_q   <= max_h_d;
            full_q    <= full_d;
            holes_q   <= holes_d;
        end
    end

    // Data for the row issued last cycle is on row_info now.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        clr     = 1'b0;
        samp    = 1'b0;
        calc    = 1'b0;
        srow    = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    row_d   = '0;
                    clr     = 1'b1;
                end
            end
            SCAN: begin
                samp = (row_q != 6'd0);
                srow = row_q - 6'd1;
                if (row_q == LAST_ROW) begin
                    state_d = DRAIN;
                end else begin
                    row_d = row_q + 6'd1;
                end
            end
            DRAIN: begin
                samp    = 1'b1;
                calc    = 1'b1;
                srow    = row_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic [6:0] hfull;
    logic [4:0] hval;
    logic [3:0] hole_inc;
    logic [8:0] hsum;
    logic [4:0] hc;

    always_comb begin
        heights_d = heights_q;
        min_col_d = min_col_q;
        max_h_d   = max_h_q;
        full_d    = full_q;
        holes_d   = holes_q;
        hfull     = ROWS_W - {1'b0, srow};
        hval      = hfull[4:0];
        hole_inc  = '0;
        hsum      = '0;
        hc        = '0;
        if (clr) begin
            heights_d = '0;
            min_col_d = '0;
            max_h_d   = '0;
            full_d    = '0;
            holes_d   = '0;
        end else if (samp) begin
            // A column is "seen" once its height is nonzero.
            for (int c = 0; c < 10; c++) begin
                if (heights_q[5*c +: 5] == 5'd0) begin
                    if (row_info[c]) begin
                        heights_d[5*c +: 5] = hval;
                    end
                end else if (!row_info[c]) begin
                    hole_inc = hole_inc + 4'd1;
                end
            end
            if (row_info == 10'h3FF) begin
                full_d = full_q + 6'd1;
            end
            hsum    = {1'b0, holes_q} + {5'd0, hole_inc};
            holes_d = hsum[8] ? 8'hFF : hsum[7:0];
        end
        if (calc) begin
            min_col_d = '0;
            max_h_d   = heights_d[4:0];
            hc        = heights_d[4:0];
            for (int c = 1; c < 10; c++) begin
                if (heights_d[5*c +: 5] < hc) begin
                    hc        = heights_d[5*c +: 5];
                    min_col_d = 4'(c);
                end
                if (heights_d[5*c +: 5] > max_h_d) begin
                    max_h_d = heights_d[5*c +: 5];
                end
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign row_req    = (state_q == SCAN);
    assign row        = row_q;
    assign heights    = heights_q;
    assign min_col    = min_col_q;
    assign max_height = max_h_q;
    assign full_rows  = full_q;
    assign holes      = holes_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a one-cycle-latency host board model
// and hand-computed expected results for a few board patterns.
module tb_board_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        row_req;
    logic [5:0]  row;
    logic [9:0]  row_info;
    logic [49:0] heights;
    logic [3:0]  min_col;
    logic [4:0]  max_height;
    logic [5:0]  full_rows;
    logic [7:0]  holes;

    int n_run;
    int n_fail;

    logic [9:0] board [0:63];

    int done_cyc;
    int done_cnt;
    int seq_bad;

    board_scanner #(.ROWS(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .row_req    (row_req),
        .row        (row),
        .row_info   (row_info),
        .heights    (heights),
        .min_col    (min_col),
        .max_height (max_height),
        .full_rows  (full_rows),
        .holes      (holes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host board port: data for the requested row appears one cycle later.
    always @(posedge clk) begin
        if (row_req) row_info <= board[row];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < 64; r++) board[r] = 10'h000;
    endtask

    // mode 0: start pulse; 1: extra start pulses mid-scan; 2: start held.
    task automatic do_scan(input int mode);
        int ncyc;
        ncyc     = (mode == 2) ? 22 : 25;
        done_cyc = -1;
        done_cnt = 0;
        seq_bad  = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (mode != 2) start = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            if (row_req !== (cyc <= 20)) seq_bad++;
            if (cyc <= 20 && row !== 6'(cyc - 1)) seq_bad++;
            if (busy !== (cyc <= 22)) seq_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mode == 1) start = (cyc == 4 || cyc == 9 || cyc == 21);
        end
        start = (mode == 2);
    endtask

    task automatic chk_res(input string tag, input logic [49:0] h,
                           input logic [3:0] mc, input logic [4:0] mh,
                           input logic [5:0] fr, input logic [7:0] ho);
        chk({tag, "_heights"}, 64'(heights), 64'(h));
        chk({tag, "_min_col"}, 64'(min_col), 64'(mc));
        chk({tag, "_max_h"}, 64'(max_height), 64'(mh));
        chk({tag, "_full"}, 64'(full_rows), 64'(fr));
        chk({tag, "_holes"}, 64'(holes), 64'(ho));
    endtask

    logic [49:0] exp_h;

    initial begin
        n_run    = 0;
        n_fail   = 0;
        start    = 1'b0;
        row_info = 10'h000;
        reset    = 1'b1;
        clear_board();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", 64'({done, row_req, row, heights, min_col,
                             max_height, full_rows, holes}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Empty board
        do_scan(0);
        chk("empty_seq", 64'(seq_bad), 64'd0);
        chk("empty_done_cyc", 64'(done_cyc), 64'd22);
        chk("empty_done_cnt", 64'(done_cnt), 64'd1);
        chk_res("empty", 50'd0, 4'd0, 5'd0, 6'd0, 8'd0);

        // Column 3 filled in rows 15..19
        clear_board();
        for (int r = 15; r < 20; r++) board[r] = 10'h008;
        do_scan(0);
        chk("col3_done_cyc", 64'(done_cyc), 64'd22);
        exp_h = 50'd0;
        exp_h[19:15] = 5'd5;
        chk_res("col3", exp_h, 4'd0, 5'd5, 6'd0, 8'd0);

        // Two full bottom rows plus a single cell in row 10, col 0
        clear_board();
        board[10] = 10'h001;
        board[18] = 10'h3FF;
        board[19] = 10'h3FF;
        do_scan(1);
        chk("mid_start_seq", 64'(seq_bad), 64'd0);
        chk("mid_start_done_cyc", 64'(done_cyc), 64'd22);
        chk("mid_start_done_cnt", 64'(done_cnt), 64'd1);
        exp_h = 50'd0;
        exp_h[4:0] = 5'd10;
        for (int c = 1; c < 10; c++) exp_h[5*c +: 5] = 5'd2;
        chk_res("full2", exp_h, 4'd1, 5'd10, 6'd2, 8'd7);

        // Top row full: every column height 20, 19 empty rows of holes below
        clear_board();
        board[0] = 10'h3FF;
        do_scan(0);
        for (int c = 0; c < 10; c++) exp_h[5*c +: 5] = 5'd20;
        chk_res("top", exp_h, 4'd0, 5'd20, 6'd1, 8'd190);

        // Reset in the middle of a scan, then a fresh scan
        clear_board();
        board[10] = 10'h001;
        board[19] = 10'h3FF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_async", 64'({busy, done, row_req, row}), 64'd0);
        @(negedge clk);
        chk("midrst_outs", 64'({busy, done, row_req, row, heights, min_col,
                                max_height, full_rows, holes}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);
        clear_board();
        for (int r = 15; r < 20; r++) board[r] = 10'h008;
        do_scan(0);
        chk("post_rst_done_cyc", 64'(done_cyc), 64'd22);
        exp_h = 50'd0;
        exp_h[19:15] = 5'd5;
        chk_res("post_rst", exp_h, 4'd0, 5'd5, 6'd0, 8'd0);

        // Start held high: back-to-back scans
        do_scan(2);
        chk("hold_done_cyc", 64'(done_cyc), 64'd22);
        @(negedge clk);
        chk("hold_gap", 64'({busy, row_req}), 64'd0);
        @(negedge clk);
        chk("hold_restart", 64'({row_req, row}), 64'({1'b1, 6'd0}));
        start = 1'b0;
        done_cyc = -1;
        for (int cyc = 2; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        end
        chk("hold_done2_cyc", 64'(done_cyc), 64'd22);
        chk_res("hold2", exp_h, 4'd0, 5'd5, 6'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
